// File: rtl/npc_regfile_pkg.sv
// npc_pkg: shared width, register-index type and zero-register constant for the register file
// Contents:
//   XLEN      default data width
//   NREG      default register count
//   reg_idx_t register index type for the default register count
//   REG_ZERO  hard-wired zero register index
package npc_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);
    typedef logic [AW-1:0] reg_idx_t;
    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/npc_regfile_sb.sv
// npc_regfile_sb: busy-bit scoreboard, one pending-producer bit per register
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_set_en      issue strobe
//   i_set_idx     register claimed by the issue
//   i_clr         per-register clear vector from this cycle's writes
//   i_raddr       NRD packed lookup addresses
//   o_busy        NRD busy bits, one per lookup address
module npc_regfile_sb #(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [AW-1:0]     i_set_idx,
    input  logic [NREG-1:0]   i_clr,
    input  logic [NRD*AW-1:0] i_raddr,
    output logic [NRD-1:0]    o_busy
);
    import npc_pkg::*;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    always_comb begin
        w_set = '0;
        w_set[i_set_idx] = i_set_en && i_set_idx != AW'(REG_ZERO);
    end
    // Set is applied after clear so a same-cycle issue (the newer producer) keeps the bit.
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_busy <= '0;
        else r_busy <= (r_busy & ~i_clr) | w_set;
    for (genvar r = 0; r < NRD; r++) begin : g_rd
        assign o_busy[r] = r_busy[i_raddr[r*AW +: AW]];
    end
endmodule

// File: rtl/npc_regfile.sv
// npc_regfile: flop-based register file with two write ports, NRD read ports and busy scoreboard
// Build option: define NPC_REGFILE_BYPASS_EN to forward same-cycle writes to read ports.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   we, waddr, wdata    two write ports, port 1 has priority
//   iss_valid, iss_rd   issue strobe marking iss_rd busy
//   raddr, rdata, rbusy NRD combinational read ports with busy flags
//   dbg_addr, dbg_data  side-effect-free debug read, never bypassed
module npc_regfile #(
    parameter int XLEN = npc_pkg::XLEN,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          we,
    input  logic [2*AW-1:0]     waddr,
    input  logic [2*XLEN-1:0]   wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);
    import npc_pkg::*;
    logic [XLEN-1:0] r_mem [NREG];
    logic [1:0]      w_wen;
    logic [NREG-1:0] w_clr;
    logic [NRD-1:0]  w_busy;
    // Writes to x0 are masked here so x0 is never written, cleared or forwarded.
    for (genvar p = 0; p < 2; p++) begin : g_wen
        assign w_wen[p] = we[p] && waddr[p*AW +: AW] != AW'(REG_ZERO);
    end
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NREG; i++)
            w_clr[i] = (w_wen[0] && waddr[0 +: AW] == AW'(i)) || (w_wen[1] && waddr[AW +: AW] == AW'(i));
    end
    // Port 1 is assigned last so it wins a same-register collision.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else begin
            if (w_wen[0]) r_mem[waddr[0 +: AW]] <= wdata[0 +: XLEN];
            if (w_wen[1]) r_mem[waddr[AW +: AW]] <= wdata[XLEN +: XLEN];
        end
    assign dbg_data = r_mem[dbg_addr];
    npc_regfile_sb #(.NREG(NREG), .NRD(NRD)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .i_set_en  (iss_valid),
        .i_set_idx (iss_rd),
        .i_clr     (w_clr),
        .i_raddr   (raddr),
        .o_busy    (w_busy)
    );
    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = raddr[r*AW +: AW];
`ifdef NPC_REGFILE_BYPASS_EN
        logic w_hit0, w_hit1;
        assign w_hit0 = w_wen[0] && waddr[0 +: AW] == w_ra;
        assign w_hit1 = w_wen[1] && waddr[AW +: AW] == w_ra;
        assign rdata[r*XLEN +: XLEN] = w_hit1 ? wdata[XLEN +: XLEN] : w_hit0 ? wdata[0 +: XLEN] : r_mem[w_ra];
        assign rbusy[r] = w_busy[r] && !(w_hit0 || w_hit1);
`else
        assign rdata[r*XLEN +: XLEN] = r_mem[w_ra];
        assign rbusy[r] = w_busy[r];
`endif
    end
endmodule

// File: tb/tb_npc_regfile.sv
// tb_npc_regfile: directed vector bench for npc_regfile (default parameters)
module tb_npc_regfile;
`ifdef NPC_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  we = '0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    int n_chk = 0;
    int n_fail = 0;

    npc_regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .raddr(raddr), .rdata(rdata),
        .rbusy(rbusy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  ra0, ra1, da;
        logic [31:0] e0, e1, ed;
        logic [1:0]  eb;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        we = v.we;
        waddr = {v.wa1, v.wa0};
        wdata = {v.wd1, v.wd0};
        iss_valid = v.iv;
        iss_rd = v.ird;
        raddr = {v.ra1, v.ra0};
        dbg_addr = v.da;
    endtask

    initial begin
        vecs[0]  = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 2'b00};
        vecs[1]  = '{2'b01, 5'd0,  5'd0,  32'h1234, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 2'b00};
        vecs[2]  = '{2'b11, 5'd7,  5'd7,  32'h1, 32'h2, 1'b0, 5'd0, 5'd0, 5'd5, 5'd5, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        vecs[3]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd7, 32'h2, 32'h0, 32'h2, 2'b00};
        vecs[4]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7, 5'd9, 32'h0, 32'h2, 32'h0, 2'b00};
        vecs[5]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 2'b01};
        vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 2'b01};
        vecs[7]  = '{2'b10, 5'd0,  5'd9,  32'h0, 32'h55, 1'b0, 5'd0, 5'd9, 5'd0, 5'd9, BYP ? 32'h55 : 32'h0, 32'h0, 32'h0, BYP ? 2'b00 : 2'b01};
        vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 32'h55, 32'h55, 32'h55, 2'b00};
        vecs[9]  = '{2'b01, 5'd9,  5'd0,  32'h66, 32'h0, 1'b1, 5'd9, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 32'h55, 2'b00};
        vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd9, 32'h66, 32'h0, 32'h66, 2'b01};
        vecs[11] = '{2'b01, 5'd3,  5'd0,  32'hA5A5A5A5, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 5'd3, 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0, 2'b00};
        vecs[12] = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b1, 5'd0, 5'd3, 5'd9, 5'd3, 32'hA5A5A5A5, 32'h66, 32'hA5A5A5A5, 2'b10};
        vecs[13] = '{2'b10, 5'd0,  5'd3,  32'h0, 32'h77, 1'b0, 5'd0, 5'd0, 5'd9, 5'd0, 32'h0, 32'h66, 32'h0, 2'b10};
        vecs[14] = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 5'd3, 32'h77, 32'h0, 32'h77, 2'b00};
        vecs[15] = '{2'b11, 5'd12, 5'd12, 32'h11, 32'h22, 1'b0, 5'd0, 5'd12, 5'd12, 5'd12, BYP ? 32'h22 : 32'h0, BYP ? 32'h22 : 32'h0, 32'h0, 2'b00};
        vecs[16] = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd4, 5'd12, 32'h22, 32'h0, 32'h22, 2'b00};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("reset_rdata_%0d", i), rdata, 64'h0);
            chk($sformatf("reset_dbg_%0d", i), {32'h0, dbg_data}, 64'h0);
            chk($sformatf("reset_rbusy_%0d", i), {62'h0, rbusy}, 64'h0);
        end

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            drive(vecs[k]);
            #1;
            chk($sformatf("v%0d_rdata0", k), {32'h0, rdata[31:0]}, {32'h0, vecs[k].e0});
            chk($sformatf("v%0d_rdata1", k), {32'h0, rdata[63:32]}, {32'h0, vecs[k].e1});
            chk($sformatf("v%0d_dbg", k), {32'h0, dbg_data}, {32'h0, vecs[k].ed});
            chk($sformatf("v%0d_rbusy", k), {62'h0, rbusy}, {62'h0, vecs[k].eb});
        end

        @(negedge clk);
        we = '0;
        iss_valid = 1'b1;
        iss_rd = 5'd4;
        @(negedge clk);
        iss_rd = 5'd6;
        @(negedge clk);
        iss_valid = 1'b0;
        raddr = {5'd6, 5'd4};
        #1;
        chk("pre_rst_busy", {62'h0, rbusy}, {62'h0, 2'b11});
        #1;
        rst = 1'b0;
        raddr = {5'd9, 5'd3};
        dbg_addr = 5'd12;
        #1;
        chk("mid_rst_rdata", rdata, 64'h0);
        chk("mid_rst_dbg", {32'h0, dbg_data}, 64'h0);
        chk("mid_rst_busy9", {62'h0, rbusy}, 64'h0);
        raddr = {5'd6, 5'd4};
        #1;
        chk("mid_rst_busy46", {62'h0, rbusy}, 64'h0);

        @(negedge clk);
        rst = 1'b1;
        we = 2'b01;
        waddr = {5'd0, 5'd4};
        wdata = {32'h0, 32'hAB};
        iss_valid = 1'b1;
        iss_rd = 5'd6;
        @(negedge clk);
        we = '0;
        iss_valid = 1'b0;
        raddr = {5'd6, 5'd4};
        #1;
        chk("post_rst_rdata", rdata, {32'h0, 32'hAB});
        chk("post_rst_busy", {62'h0, rbusy}, {62'h0, 2'b10});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
